// File: rtl/proc_pkg.sv
// Shared types for the parametrised processor control FSM.
// Holds the opcode, state and ALU-function encodings plus a small helper
// that maps an ALU opcode onto the ALU function select.
package proc_pkg;

  // Instruction opcodes carried in the top three bits of the instruction.
  // 3'b110 and 3'b111 are undefined and reported as illegal.
  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_MVNZ = 3'b101
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3
  } state_t;

  // ALU function select presented to the datapath.
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10
  } alu_op_t;

  function automatic alu_op_t alu_decode(input opcode_t op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/proc_controller_n_onehot_dec.sv
// Binary-to-one-hot register select decoder.
// Ports:
//   sel    : register index, $clog2(NREG) bits
//   en     : when low the output is all zeros
//   onehot : NREG-bit vector with at most bit [sel] set
module onehot_dec #(
  parameter int NREG = 8
) (
  input  logic [$clog2(NREG)-1:0] sel,
  input  logic                    en,
  output logic [NREG-1:0]         onehot
);

  localparam int RS_W = $clog2(NREG);

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      onehot[i] = en && (sel == RS_W'(i));
    end
  end

endmodule

// File: rtl/proc_controller_n.sv
// Control FSM for the simple bus-based processor datapath.
// Latches an instruction {opcode, XXX, YYY} from DIN, then sequences the
// register-bus enables, A/G loads, DIN drive and done over T1..T3.
// Ports:
//   clk, resetn     : rising-edge clock, asynchronous active-low reset
//   run             : start request, honoured only in IDLE
//   din             : DIN bus; instruction sampled in T0
//   g_zero          : datapath reports G == 0 (used by MVNZ)
//   r_out / r_in    : one-hot register drive / load enables
//   din_out, a_in, g_in, g_out, alu_op : datapath controls
//   done, illegal   : one-cycle retire / undefined-opcode pulses
//   busy            : FSM not in IDLE
//   instr_cnt       : retired-instruction counter (wraps)
module proc_controller_n
  import proc_pkg::*;
#(
  parameter int NREG  = 8,
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             run,
  input  logic [DW-1:0]    din,
  input  logic             g_zero,
  output logic [NREG-1:0]  r_out,
  output logic [NREG-1:0]  r_in,
  output logic             din_out,
  output logic             a_in,
  output logic             g_in,
  output logic             g_out,
  output logic [1:0]       alu_op,
  output logic             done,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int RS_W = $clog2(NREG);
  localparam int IR_W = 3 + 2 * RS_W;

  state_t               state_q, state_d;
  logic [IR_W-1:0]      ir_q, ir_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  opcode_t              op;
  logic [RS_W-1:0]      xxx, yyy;
  logic                 r_out_en, r_in_en;
  logic [RS_W-1:0]      r_out_sel, r_in_sel;
  alu_op_t              alu_op_e;

  assign op  = opcode_t'(ir_q[IR_W-1 -: 3]);
  assign xxx = ir_q[2*RS_W-1 -: RS_W];
  assign yyy = ir_q[RS_W-1:0];

  // Only the low IR_W bits of DIN form the instruction; upper bits are data.
  if (DW > IR_W) begin : g_din_hi
    logic unused_din_hi;
    assign unused_din_hi = ^din[DW-1:IR_W];
  end

  // NOTE: every signal gets a default before the case, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    r_out_en  = 1'b0;
    r_out_sel = yyy;
    r_in_en   = 1'b0;
    r_in_sel  = xxx;
    din_out   = 1'b0;
    a_in      = 1'b0;
    g_in      = 1'b0;
    g_out     = 1'b0;
    alu_op_e  = ALU_ADD;
    done      = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1: begin
        state_d = S_IDLE;
        case (op)
          OP_MV: begin
            r_out_en = 1'b1;
            r_in_en  = 1'b1;
            done     = 1'b1;
          end
          OP_MVI: begin
            din_out = 1'b1;
            r_in_en = 1'b1;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            // First operand comes from XXX into A.
            r_out_en  = 1'b1;
            r_out_sel = xxx;
            a_in      = 1'b1;
            state_d   = S_T2;
          end
          OP_MVNZ: begin
            // Retires either way; the move only happens when G is non-zero.
            r_out_en = !g_zero;
            r_in_en  = !g_zero;
            done     = 1'b1;
          end
          default: begin
            illegal = 1'b1;
            done    = 1'b1;
          end
        endcase
      end
      S_T2: begin
        r_out_en = 1'b1;
        g_in     = 1'b1;
        alu_op_e = alu_decode(op);
        state_d  = S_T3;
      end
      S_T3: begin
        g_out   = 1'b1;
        r_in_en = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ir_d  = (state_q == S_T0) ? din[IR_W-1:0] : ir_q;
    cnt_d = done ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  onehot_dec #(.NREG(NREG)) u_dec_out (
    .sel    (r_out_sel),
    .en     (r_out_en),
    .onehot (r_out)
  );

  onehot_dec #(.NREG(NREG)) u_dec_in (
    .sel    (r_in_sel),
    .en     (r_in_en),
    .onehot (r_in)
  );

  assign alu_op    = alu_op_e;
  assign busy      = (state_q != S_IDLE);
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_proc_controller_n.sv
// Scoreboard bench for proc_controller_n. Three instances (NREG=8/CNT_W=16,
// NREG=4/CNT_W=4, NREG=16/CNT_W=4) each get the same directed sequence
// followed by a random instruction stream. The stimulus pushes the expected
// control word for every busy cycle of each instruction; an independent
// monitor pops one entry per busy cycle at the falling edge and compares,
// and checks idle/reset outputs, the retire counter and the bus invariants.
module tb_proc_controller_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Control word of one cycle, register vectors widened to 16 bits.
  typedef struct packed {
    logic [15:0] r_out;
    logic [15:0] r_in;
    logic        din_out;
    logic        a_in;
    logic        g_in;
    logic        g_out;
    logic [1:0]  alu_op;
    logic        done;
    logic        illegal;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int NR  = (g == 0) ? 8 : ((g == 1) ? 4 : 16);
    localparam int CW  = (g == 0) ? 16 : 4;
    localparam int RSW = $clog2(NR);
    localparam int IRW = 3 + 2 * RSW;

    logic          resetn, run, g_zero;
    logic [15:0]   din;
    logic [NR-1:0] r_out, r_in;
    logic          din_out, a_in, g_in, g_out, done, illegal, busy;
    logic [1:0]    alu_op;
    logic [CW-1:0] instr_cnt;

    exp_t exp_q[$];
    bit   fin = 1'b0;
    int   mon_cnt = 0;

    proc_controller_n #(.NREG(NR), .DW(16), .CNT_W(CW)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .run       (run),
      .din       (din),
      .g_zero    (g_zero),
      .r_out     (r_out),
      .r_in      (r_in),
      .din_out   (din_out),
      .a_in      (a_in),
      .g_in      (g_in),
      .g_out     (g_out),
      .alu_op    (alu_op),
      .done      (done),
      .illegal   (illegal),
      .busy      (busy),
      .instr_cnt (instr_cnt)
    );

    // Reference model: the sequence of control words an instruction produces,
    // one per busy cycle, starting with the all-quiet fetch cycle.
    task automatic push_cycles(input int op, input int x, input int y, input bit gz,
                               input bit abort);
      exp_t        e;
      logic [15:0] bx, by;
      bx = 16'(1) << x;
      by = 16'(1) << y;
      e = '0;
      exp_q.push_back(e);
      case (op)
        0: begin e.r_out = by; e.r_in = bx; e.done = 1'b1; end
        1: begin e.din_out = 1'b1; e.r_in = bx; e.done = 1'b1; end
        2, 3, 4: begin e.r_out = bx; e.a_in = 1'b1; end
        5: begin
          e.done = 1'b1;
          if (!gz) begin e.r_out = by; e.r_in = bx; end
        end
        default: begin e.illegal = 1'b1; e.done = 1'b1; end
      endcase
      exp_q.push_back(e);
      if (op >= 2 && op <= 4 && !abort) begin
        e = '0; e.r_out = by; e.g_in = 1'b1; e.alu_op = 2'(op - 2);
        exp_q.push_back(e);
        e = '0; e.g_out = 1'b1; e.r_in = bx; e.done = 1'b1;
        exp_q.push_back(e);
      end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns likewise.
    task automatic issue(input int op, input int x, input int y, input bit gz, input bit abort);
      int           len;
      bit           ab;
      logic [15:0]  w;
      logic [RSW-1:0] xs, ys;
      xs  = RSW'(x);
      ys  = RSW'(y);
      len = (op >= 2 && op <= 4) ? 4 : 2;
      ab  = abort && (len == 4);
      w   = 16'($urandom);
      w[IRW-1:0] = {3'(op), xs, ys};
      push_cycles(op, int'(xs), int'(ys), gz, ab);
      run = 1'b1; din = w; g_zero = gz;
      @(posedge clk); #1;                 // T0: instruction on DIN
      run = 1'($urandom);                 // ignored while busy
      @(posedge clk); #1;                 // T1: DIN now carries other data
      din = 16'($urandom);
      if (ab) begin
        @(posedge clk); #1;               // T2
        resetn = 1'b0;
        #1;
        check("abort_outs", 64'({r_out, r_in, din_out, a_in, g_in, g_out, alu_op, done, illegal, busy}), 64'd0);
        check("abort_cnt", 64'(instr_cnt), 64'd0);
        run = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
      end else begin
        repeat (len - 1) begin @(posedge clk); #1; end
      end
      run = 1'b0;
    endtask

    initial begin
      resetn = 1'b0; run = 1'b0; din = '0; g_zero = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      issue(0, 2, 5, 1'b0, 1'b0);   // MV R2,R5
      issue(1, 7, 0, 1'b0, 1'b0);   // MVI R7
      issue(3, 3, 6, 1'b0, 1'b0);   // SUB R3,R6
      issue(5, 0, 1, 1'b1, 1'b0);   // MVNZ, G zero
      issue(5, 0, 1, 1'b0, 1'b0);   // MVNZ, G non-zero
      issue(6, 1, 2, 1'b0, 1'b0);   // illegal
      issue(7, 3, 0, 1'b0, 1'b0);   // illegal
      issue(2, 4, 4, 1'b0, 1'b0);   // ADD Rx,Rx
      issue(4, 1, 3, 1'b0, 1'b0);   // AND
      issue(2, 1, 2, 1'b0, 1'b1);   // ADD aborted by reset in T2
      issue(0, 1, 1, 1'b0, 1'b0);   // clean restart, self-move
      for (int i = 0; i < 70; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        issue($urandom_range(0, 7), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
              1'($urandom), $urandom_range(0, 19) == 0);
      end
      repeat (3) @(posedge clk);
      fin = 1'b1;
    end

    // Monitor: one scoreboard entry per busy cycle, quiet outputs otherwise.
    initial begin
      exp_t a, e;
      forever begin
        @(negedge clk);
        a = '0;
        a.r_out   = 16'(r_out);
        a.r_in    = 16'(r_in);
        a.din_out = din_out;
        a.a_in    = a_in;
        a.g_in    = g_in;
        a.g_out   = g_out;
        a.alu_op  = alu_op;
        a.done    = done;
        a.illegal = illegal;
        check("onehot_r_out", 64'($onehot0(r_out)), 64'd1);
        check("onehot_r_in", 64'($onehot0(r_in)), 64'd1);
        check("single_driver", 64'($countones({|r_out, din_out, g_out}) <= 1), 64'd1);
        if (!resetn) begin
          mon_cnt = 0;
          check("reset_outs", 64'({a, busy}), 64'd0);
          check("reset_cnt", 64'(instr_cnt), 64'd0);
        end else if (busy) begin
          check("busy_has_expect", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ctrl_word", 64'(a), 64'(e));
            check("instr_cnt", 64'(instr_cnt), 64'(mon_cnt));
            if (e.done) mon_cnt = (mon_cnt + 1) % (1 << CW);
          end
        end else begin
          check("idle_outs", 64'(a), 64'd0);
          check("idle_cnt", 64'(instr_cnt), 64'(mon_cnt));
        end
      end
    end
  end

  initial begin
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk);
      if (cfg[0].fin && cfg[1].fin && cfg[2].fin) break;
    end
    check("stimulus_finished", 64'({cfg[0].fin, cfg[1].fin, cfg[2].fin}), 64'h7);
    check("queue_empty_n8", 64'(cfg[0].exp_q.size()), 64'd0);
    check("queue_empty_n4", 64'(cfg[1].exp_q.size()), 64'd0);
    check("queue_empty_n16", 64'(cfg[2].exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
